grant_session_ctrl: RTL and testbench

// - Downstream consumer of the 4-requester arbiter's registered grant outputs.
// - Turns each newly observed one-hot grant into a bounded access session on a shared resource:
//   - BURST_LEN valid/ready beats, tagged with the owner index.
//   - At the end: a one-cycle release pulse back to the owning requester.
// - Keeps per-requester service counts and a sticky error flag for illegal (multi-hot) grants.

---
 rtl/grant_session_ctrl_pkg.sv | 33 +++
 rtl/grant_session_ctrl_if.sv | 31 +++
 rtl/grant_session_ctrl_timer.sv | 28 ++
 rtl/grant_session_ctrl.sv | 123 ++++++++++++
 tb/tb_grant_session_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grant_session_ctrl_pkg.sv
// Shared types and helpers for the grant session controller.
// Requester count, FSM state encoding and one-hot utilities.
package b03_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } sess_state_t;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic multihot4(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/grant_session_ctrl_if.sv
// Grant/session bundle between the arbiter side and the session controller.
// The slave modport is the controller's view.
interface grant_session_ctrl_if #(
  parameter int CNT_W = 8
);
  import b03_pkg::*;

  logic [NREQ-1:0]       i_grant_in;
  logic                  i_sess_ready;
  logic                  o_sess_valid;
  logic [1:0]            o_sess_owner;
  logic [2:0]            o_beat_cnt;
  logic                  o_busy;
  logic [NREQ-1:0]       o_release;
  logic                  o_abort;
  logic                  o_err_multi;
  logic [NREQ*CNT_W-1:0] o_svc_cnt;

  modport master (
    output i_grant_in, i_sess_ready,
    input  o_sess_valid, o_sess_owner, o_beat_cnt, o_busy,
    input  o_release, o_abort, o_err_multi, o_svc_cnt
  );

  modport slave (
    input  i_grant_in, i_sess_ready,
    output o_sess_valid, o_sess_owner, o_beat_cnt, o_busy,
    output o_release, o_abort, o_err_multi, o_svc_cnt
  );

endinterface

// File: rtl/grant_session_ctrl_timer.sv
// Stall counter for an active session; expired flags TIMEOUT-1 stalled cycles seen.
// The count parks at its top value so it cannot wrap while still stalled.
module grant_sess_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic          w_top;

  assign w_top   = (r_cnt == CW'(TIMEOUT - 1));
  assign expired = w_top;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (inc && !w_top) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/grant_session_ctrl.sv
// Turns each newly observed one-hot arbiter grant into a bounded beat session,
// with release/abort pulses, saturating per-requester service counts and a multi-hot flag.
module grant_session_ctrl
  import b03_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  grant_session_ctrl_if.slave  bus
);

  sess_state_t           r_state, w_state_next;
  logic [NREQ-1:0]       r_grant_q;
  logic                  r_served, w_served_next;
  logic [1:0]            r_owner, w_owner_next;
  logic [2:0]            r_beat_cnt, w_beat_next;
  logic                  r_err_multi;
  logic [NREQ-1:0]       w_release;
  logic                  w_abort;
  logic                  w_chg;
  logic                  w_active;
  logic                  w_expired;
  logic                  w_last;
  logic [NREQ*CNT_W-1:0] w_svc_flat;

  assign w_chg    = (bus.i_grant_in != r_grant_q);
  assign w_active = (r_state == ACTIVE);
  assign w_last   = (r_beat_cnt == 3'(BURST_LEN - 1));

  grant_sess_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!w_active || bus.i_sess_ready),
    .inc     (w_active && !bus.i_sess_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant_q   <= '0;
      r_served    <= 1'b0;
      r_owner     <= 2'd0;
      r_beat_cnt  <= 3'd0;
      r_err_multi <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_grant_q   <= bus.i_grant_in;
      r_served    <= w_served_next;
      r_owner     <= w_owner_next;
      r_beat_cnt  <= w_beat_next;
      r_err_multi <= r_err_multi | multihot4(bus.i_grant_in);
    end
  end

  // A grant edge this cycle already clears served, so it may start a session at once.
  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_beat_next   = r_beat_cnt;
    w_served_next = r_served;
    w_release     = '0;
    w_abort       = 1'b0;
    case (r_state)
      IDLE: begin
        if (onehot4(bus.i_grant_in) && !(r_served && !w_chg)) begin
          w_owner_next = enc4(bus.i_grant_in);
          w_state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_chg || (w_expired && !bus.i_sess_ready)) begin
          w_abort      = 1'b1;
          w_beat_next  = 3'd0;
          w_state_next = IDLE;
        end else if (bus.i_sess_ready) begin
          if (w_last) begin
            w_beat_next  = 3'd0;
            w_state_next = DONE;
          end else begin
            w_beat_next = r_beat_cnt + 3'd1;
          end
        end
      end
      DONE: begin
        w_release     = 4'b0001 << r_owner;
        w_served_next = 1'b1;
        w_state_next  = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (w_chg) begin
      w_served_next = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_svc
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_release[gi] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_svc_flat[gi*CNT_W +: CNT_W] = r_cnt;
  end

  assign bus.o_sess_valid = w_active;
  assign bus.o_sess_owner = r_owner;
  assign bus.o_beat_cnt   = r_beat_cnt;
  assign bus.o_busy       = (r_state != IDLE);
  assign bus.o_release    = reset ? '0 : w_release;
  assign bus.o_abort      = w_abort && !reset;
  assign bus.o_err_multi  = r_err_multi;
  assign bus.o_svc_cnt    = w_svc_flat;

endmodule

// File: tb/tb_grant_session_ctrl.sv
// Directed bench for grant_session_ctrl; two instances (8-bit and 2-bit counters) share stimulus.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_grant_session_ctrl;
  import b03_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] grant;
  logic       ready;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  grant_session_ctrl_if #(.CNT_W(8)) bus8();
  grant_session_ctrl_if #(.CNT_W(2)) bus2();

  assign bus8.i_grant_in   = grant;
  assign bus8.i_sess_ready = ready;
  assign bus2.i_grant_in   = grant;
  assign bus2.i_sess_ready = ready;

  grant_session_ctrl #(.BURST_LEN(4), .TIMEOUT(16), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave)
  );
  grant_session_ctrl #(.BURST_LEN(4), .TIMEOUT(16), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus8.o_sess_valid, bus8.o_busy, bus8.o_abort, bus8.o_err_multi} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got %b want 0000", {bus8.o_sess_valid, bus8.o_busy, bus8.o_abort, bus8.o_err_multi});
    end
    total++;
    if ({bus8.o_release, bus8.o_beat_cnt, bus8.o_sess_owner} !== 9'd0) begin
      bad++;
      $display("FAIL reset_fields got %h want 0", {bus8.o_release, bus8.o_beat_cnt, bus8.o_sess_owner});
    end
    total++;
    if (bus8.o_svc_cnt !== 32'd0 || bus2.o_svc_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_svc got %h/%h want 0/0", bus8.o_svc_cnt, bus2.o_svc_cnt);
    end
    $display("tb: reset state checked");
    next_cycle();
  endtask

  task automatic test_normal();
    grant = 4'b0100;
    ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus8.o_sess_valid !== 1'b0) begin
      bad++;
      $display("FAIL norm_latency valid got %b want 0", bus8.o_sess_valid);
    end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({bus8.o_sess_valid, bus8.o_sess_owner, bus8.o_beat_cnt} !== {1'b1, 2'd2, 3'(k)}) begin
        bad++;
        $display("FAIL norm_beat%0d got %h want %h", k,
                 {bus8.o_sess_valid, bus8.o_sess_owner, bus8.o_beat_cnt}, {1'b1, 2'd2, 3'(k)});
      end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if ({bus8.o_release, bus8.o_sess_valid, bus8.o_busy} !== {4'b0100, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL norm_release got %b want 010001", {bus8.o_release, bus8.o_sess_valid, bus8.o_busy});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({bus8.o_release, bus8.o_busy} !== 5'b00000) begin
      bad++;
      $display("FAIL norm_after got %b want 00000", {bus8.o_release, bus8.o_busy});
    end
    total++;
    if (bus8.o_svc_cnt[23:16] !== 8'd1 || bus2.o_svc_cnt[5:4] !== 2'd1) begin
      bad++;
      $display("FAIL norm_svc2 got %0d/%0d want 1/1", bus8.o_svc_cnt[23:16], bus2.o_svc_cnt[5:4]);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (bus8.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL norm_no_restart busy got %b want 0", bus8.o_busy);
    end
    $display("tb: session owner=2 released");
    next_cycle();
  endtask

  task automatic test_backpressure();
    int pat [9]   = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
    int beats [9] = '{0, 1, 2, 2, 2, 2, 2, 2, 3};
    grant = 4'b0000;
    next_cycle();
    grant = 4'b0010;
    ready = 1'b1;
    next_cycle();
    for (int k = 0; k < 9; k++) begin
      ready = pat[k][0];
      @(negedge clk);
      total++;
      if ({bus8.o_sess_valid, bus8.o_abort, bus8.o_beat_cnt} !== {1'b1, 1'b0, 3'(beats[k])}) begin
        bad++;
        $display("FAIL bp_cycle%0d valid/abort/beat got %b want %b", k,
                 {bus8.o_sess_valid, bus8.o_abort, bus8.o_beat_cnt}, {1'b1, 1'b0, 3'(beats[k])});
      end
      next_cycle();
    end
    ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus8.o_release, bus8.o_abort} !== 5'b00100) begin
      bad++;
      $display("FAIL bp_release got %b want 00100", {bus8.o_release, bus8.o_abort});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (bus8.o_svc_cnt[15:8] !== 8'd1 || bus2.o_svc_cnt[3:2] !== 2'd1) begin
      bad++;
      $display("FAIL bp_svc1 got %0d/%0d want 1/1", bus8.o_svc_cnt[15:8], bus2.o_svc_cnt[3:2]);
    end
    $display("tb: backpressured session owner=1 released");
    next_cycle();
  endtask

  task automatic test_timeout();
    grant = 4'b0000;
    next_cycle();
    grant = 4'b0001;
    ready = 1'b0;
    next_cycle();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      total++;
      if ({bus8.o_sess_valid, bus8.o_abort, bus8.o_release} !== {1'b1, (k == 16), 4'b0000}) begin
        bad++;
        $display("FAIL to_stall%0d valid/abort/release got %b want %b", k,
                 {bus8.o_sess_valid, bus8.o_abort, bus8.o_release}, {1'b1, (k == 16), 4'b0000});
      end
      next_cycle();
    end
    grant = 4'b0000;
    ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus8.o_busy, bus8.o_abort, bus8.o_release} !== 6'd0 || bus8.o_svc_cnt[7:0] !== 8'd0) begin
      bad++;
      $display("FAIL to_after busy/abort/release got %b svc0 %0d want 000000 0",
               {bus8.o_busy, bus8.o_abort, bus8.o_release}, bus8.o_svc_cnt[7:0]);
    end
    $display("tb: session owner=0 timed out");
    next_cycle();
  endtask

  task automatic test_grant_change();
    grant = 4'b0010;
    ready = 1'b1;
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({bus8.o_sess_owner, bus8.o_beat_cnt} !== {2'd1, 3'(k)}) begin
        bad++;
        $display("FAIL gc_first%0d got %h want %h", k, {bus8.o_sess_owner, bus8.o_beat_cnt}, {2'd1, 3'(k)});
      end
      next_cycle();
    end
    grant = 4'b1000;
    @(negedge clk);
    total++;
    if ({bus8.o_abort, bus8.o_release, bus8.o_beat_cnt} !== {1'b1, 4'b0000, 3'd2}) begin
      bad++;
      $display("FAIL gc_abort got %b want 10000010", {bus8.o_abort, bus8.o_release, bus8.o_beat_cnt});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({bus8.o_busy, bus8.o_abort, bus8.o_beat_cnt} !== 5'd0) begin
      bad++;
      $display("FAIL gc_idle got %b want 00000", {bus8.o_busy, bus8.o_abort, bus8.o_beat_cnt});
    end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({bus8.o_sess_valid, bus8.o_sess_owner, bus8.o_beat_cnt} !== {1'b1, 2'd3, 3'(k)}) begin
        bad++;
        $display("FAIL gc_second%0d got %h want %h", k,
                 {bus8.o_sess_valid, bus8.o_sess_owner, bus8.o_beat_cnt}, {1'b1, 2'd3, 3'(k)});
      end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if (bus8.o_release !== 4'b1000) begin
      bad++;
      $display("FAIL gc_release got %b want 1000", bus8.o_release);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (bus8.o_svc_cnt !== {8'd1, 8'd1, 8'd1, 8'd0}) begin
      bad++;
      $display("FAIL gc_svc got %h want 01010100", bus8.o_svc_cnt);
    end
    $display("tb: aborted owner=1, session owner=3 released");
    next_cycle();
  endtask

  task automatic test_multi_hold();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({bus8.o_busy, bus8.o_err_multi} !== 2'b00) begin
        bad++;
        $display("FAIL hold%0d busy/err got %b want 00", k, {bus8.o_busy, bus8.o_err_multi});
      end
      next_cycle();
    end
    grant = 4'b0110;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({bus8.o_busy, bus8.o_err_multi} !== 2'b01) begin
        bad++;
        $display("FAIL multi%0d busy/err got %b want 01", k, {bus8.o_busy, bus8.o_err_multi});
      end
      next_cycle();
    end
    grant = 4'b0000;
    next_cycle();
    @(negedge clk);
    total++;
    if (bus8.o_err_multi !== 1'b1 || bus2.o_err_multi !== 1'b1) begin
      bad++;
      $display("FAIL multi_sticky got %b/%b want 1/1", bus8.o_err_multi, bus2.o_err_multi);
    end
    $display("tb: multi-hot grant flagged, held grant ignored");
    next_cycle();
  endtask

  task automatic test_saturation();
    for (int s = 0; s < 5; s++) begin
      grant = 4'b0000;
      next_cycle();
      grant = 4'b0010;
      ready = 1'b1;
      repeat (6) next_cycle();
      $display("tb: saturation session %0d owner=1", s);
    end
    @(negedge clk);
    total++;
    if (bus2.o_svc_cnt !== {2'd1, 2'd1, 2'd3, 2'd0}) begin
      bad++;
      $display("FAIL sat_cnt2 got %b want 01011100", bus2.o_svc_cnt);
    end
    total++;
    if (bus8.o_svc_cnt[15:8] !== 8'd6) begin
      bad++;
      $display("FAIL sat_cnt8 got %0d want 6", bus8.o_svc_cnt[15:8]);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    grant = 4'b0000;
    next_cycle();
    grant = 4'b0100;
    ready = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if ({bus8.o_sess_valid, bus8.o_sess_owner} !== 3'b110) begin
      bad++;
      $display("FAIL rst_active got %b want 110", {bus8.o_sess_valid, bus8.o_sess_owner});
    end
    next_cycle();
    reset = 1'b1;
    grant = 4'b0001;
    @(negedge clk);
    total++;
    if ({bus8.o_abort, bus8.o_release} !== 5'd0) begin
      bad++;
      $display("FAIL rst_no_pulse got %b want 00000", {bus8.o_abort, bus8.o_release});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({bus8.o_sess_valid, bus8.o_busy, bus8.o_abort, bus8.o_err_multi, bus8.o_release,
         bus8.o_beat_cnt, bus8.o_sess_owner} !== 13'd0) begin
      bad++;
      $display("FAIL rst_outputs got %b want 0", {bus8.o_sess_valid, bus8.o_busy, bus8.o_abort,
               bus8.o_err_multi, bus8.o_release, bus8.o_beat_cnt, bus8.o_sess_owner});
    end
    total++;
    if (bus8.o_svc_cnt !== 32'd0 || bus2.o_svc_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rst_svc got %h/%h want 0/0", bus8.o_svc_cnt, bus2.o_svc_cnt);
    end
    $display("tb: reset mid-session cleared state");
    reset = 1'b0;
    grant = 4'b0000;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    grant = 4'b0000;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_normal();
    test_backpressure();
    test_timeout();
    test_grant_change();
    test_multi_hold();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
